// File: rtl/anneal_run_sequencer.sv
// Run sequencer for the analog Ising core: walks N annealing runs through
// fetch-IC, pre-program, program, anneal and read-out, handing each result to the spin RF writer.
module anneal_run_sequencer #(
    parameter int RUN_W        = 8,
    parameter int INTERVAL_W   = 8,
    parameter int PRE_PROG_CYC = 4,
    parameter int PROG_CYC     = 4,
    parameter int READ_CYC     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [RUN_W-1:0]      i_total_runs,
    input  logic [INTERVAL_W-1:0] i_run_interval,
    output logic                  o_ic_req,
    input  logic                  i_ic_ack,
    output logic                  o_pre_prog_ic,
    output logic                  o_prog_ic,
    output logic                  o_ccii_ena,
    output logic                  o_read_out_ena,
    output logic                  o_cap_valid,
    input  logic                  i_cap_ready,
    output logic [RUN_W-1:0]      o_run_counter,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int MAX_P = (PRE_PROG_CYC > PROG_CYC)
                         ? ((PRE_PROG_CYC > READ_CYC) ? PRE_PROG_CYC : READ_CYC)
                         : ((PROG_CYC > READ_CYC) ? PROG_CYC : READ_CYC);
    localparam int P_W   = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int CNT_W = (INTERVAL_W > P_W) ? INTERVAL_W : P_W;

    // READ_HOLD is the second half of read-out: strobes stay up while capture is offered.
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_IC, S_PRE_PROG, S_PROG, S_ANNEAL,
        S_READOUT, S_READ_HOLD, S_NEXT, S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
    logic [RUN_W-1:0]      total_q, total_d;
    logic [INTERVAL_W-1:0] interval_q, interval_d;

    logic ic_req_q, ic_req_d, pre_q, pre_d, prog_q, prog_d, ccii_q, ccii_d;
    logic ro_q, ro_d, cv_q, cv_d, busy_q, busy_d, done_q, done_d;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            run_cnt_q  <= '0;
            total_q    <= '0;
            interval_q <= '0;
            ic_req_q   <= 1'b0;
            pre_q      <= 1'b0;
            prog_q     <= 1'b0;
            ccii_q     <= 1'b0;
            ro_q       <= 1'b0;
            cv_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_cnt_q  <= run_cnt_d;
            total_q    <= total_d;
            interval_q <= interval_d;
            ic_req_q   <= ic_req_d;
            pre_q      <= pre_d;
            prog_q     <= prog_d;
            ccii_q     <= ccii_d;
            ro_q       <= ro_d;
            cv_q       <= cv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        run_cnt_d  = run_cnt_q;
        total_d    = total_q;
        interval_d = interval_q;
        if (i_abort) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            run_cnt_d  = '0;
            total_d    = '0;
            interval_d = '0;
        end else begin
            case (state_q)
                S_IDLE: if (i_start) begin
                    total_d    = i_total_runs;
                    interval_d = i_run_interval;
                    run_cnt_d  = '0;
                    state_d    = (i_total_runs != '0) ? S_FETCH_IC : S_DONE;
                end
                S_FETCH_IC: if (i_ic_ack) begin
                    state_d = S_PRE_PROG;
                    cnt_d   = CNT_W'(PRE_PROG_CYC - 1);
                end
                S_PRE_PROG: if (cnt_q == '0) begin
                    state_d = S_PROG;
                    cnt_d   = CNT_W'(PROG_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                S_PROG: if (cnt_q == '0) begin
                    state_d = S_ANNEAL;
                    // a zero interval still anneals for one cycle
                    cnt_d   = (interval_q == '0) ? '0 : CNT_W'(interval_q - 1'b1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                S_ANNEAL: if (cnt_q == '0) begin
                    state_d = S_READOUT;
                    cnt_d   = CNT_W'(READ_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                S_READOUT: if (cnt_q == '0) begin
                    state_d = S_READ_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                S_READ_HOLD: if (i_cap_ready) begin
                    state_d = S_NEXT;
                end
                S_NEXT: if (run_cnt_q == total_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                    state_d   = S_FETCH_IC;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        ic_req_d = 1'b0;
        pre_d    = 1'b0;
        prog_d   = 1'b0;
        ccii_d   = 1'b0;
        ro_d     = 1'b0;
        cv_d     = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_d)
            S_FETCH_IC:  ic_req_d = 1'b1;
            S_PRE_PROG:  pre_d    = 1'b1;
            S_PROG:      prog_d   = 1'b1;
            S_ANNEAL:    ccii_d   = 1'b1;
            S_READOUT: begin
                ccii_d = 1'b1;
                ro_d   = 1'b1;
            end
            S_READ_HOLD: begin
                ccii_d = 1'b1;
                ro_d   = 1'b1;
                cv_d   = 1'b1;
            end
            S_DONE:      done_d   = 1'b1;
            default:     ;
        endcase
    end

    assign o_ic_req       = ic_req_q;
    assign o_pre_prog_ic  = pre_q;
    assign o_prog_ic      = prog_q;
    assign o_ccii_ena     = ccii_q;
    assign o_read_out_ena = ro_q;
    assign o_cap_valid    = cv_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_run_counter  = run_cnt_q;

endmodule

// File: tb/tb_anneal_run_sequencer.sv
// Directed bench for anneal_run_sequencer: run counts, stall, abort, ignored start,
// zero interval, 255 runs and asynchronous reset.
module tb_anneal_run_sequencer;

    logic       clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [7:0] i_total_runs = '0;
    logic [7:0] i_run_interval = '0;
    logic       i_ic_ack = 1'b0;
    logic       i_cap_ready = 1'b1;
    logic       o_ic_req, o_pre_prog_ic, o_prog_ic, o_ccii_ena, o_read_out_ena;
    logic       o_cap_valid, o_busy, o_done;
    logic [7:0] o_run_counter;

    int total_cnt = 0;
    int bad_cnt   = 0;

    anneal_run_sequencer dut (
        .i_clk          (clk),
        .i_rstn         (i_rstn),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_total_runs   (i_total_runs),
        .i_run_interval (i_run_interval),
        .o_ic_req       (o_ic_req),
        .i_ic_ack       (i_ic_ack),
        .o_pre_prog_ic  (o_pre_prog_ic),
        .o_prog_ic      (o_prog_ic),
        .o_ccii_ena     (o_ccii_ena),
        .o_read_out_ena (o_read_out_ena),
        .o_cap_valid    (o_cap_valid),
        .i_cap_ready    (i_cap_ready),
        .o_run_counter  (o_run_counter),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    // Monitor counters: 0 pre,1 prog,2 ccii,3 ro,4 cap_valid,5 transfers,6 done,7 ic_req,8 exclusivity errors
    int m [9];
    int s [9];
    logic [7:0] xfer_rc [64];
    initial for (int i = 0; i < 9; i++) m[i] = 0;

    always @(negedge clk) begin
        m[0] <= m[0] + int'(o_pre_prog_ic);
        m[1] <= m[1] + int'(o_prog_ic);
        m[2] <= m[2] + int'(o_ccii_ena);
        m[3] <= m[3] + int'(o_read_out_ena);
        m[4] <= m[4] + int'(o_cap_valid);
        m[5] <= m[5] + int'(o_cap_valid & i_cap_ready);
        m[6] <= m[6] + int'(o_done);
        m[7] <= m[7] + int'(o_ic_req);
        if (($countones({o_ic_req, o_pre_prog_ic, o_prog_ic, o_ccii_ena, o_done}) > 1) ||
            (o_read_out_ena && !o_ccii_ena) || (o_cap_valid && !o_read_out_ena))
            m[8] <= m[8] + 1;
        if (o_cap_valid && i_cap_ready)
            xfer_rc[m[5] % 64] <= o_run_counter;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] outs();
        return {o_ic_req, o_pre_prog_ic, o_prog_ic, o_ccii_ena,
                o_read_out_ena, o_cap_valid, o_busy, o_done};
    endfunction

    // Drives a sequence already armed with i_start: acks IC two cycles after request,
    // optionally stalls capture, re-pulses start during FETCH_IC, or aborts mid-ANNEAL.
    task automatic run_seq(input string tag, input int budget, input int cap_block,
                           input int restart_total, input int abort_run,
                           output int cycles, output int rc_done, output int first_req);
        int age = 0;
        int blk = cap_block;
        bit seen = 0;
        bit aborted = 0;
        bit restarted = 0;
        cycles = 0;
        rc_done = -1;
        first_req = 0;
        i_cap_ready = 1'b1;
        while (!seen && !aborted && cycles < budget) begin
            step();
            i_start = 1'b0;
            cycles++;
            if (o_done) begin
                seen = 1;
                rc_done = int'(o_run_counter);
            end
            if (o_ic_req) begin
                if (first_req == 0) first_req = cycles;
                age++;
                i_ic_ack = (age == 2);
                if (restart_total != 0 && age == 1 && !restarted) begin
                    i_start      = 1'b1;
                    i_total_runs = 8'(restart_total);
                    restarted    = 1;
                end
            end else begin
                age = 0;
                i_ic_ack = 1'b0;
            end
            if (o_cap_valid && blk > 0) begin
                i_cap_ready = 1'b0;
                blk--;
            end else begin
                i_cap_ready = 1'b1;
            end
            if (abort_run >= 0 && int'(o_run_counter) == abort_run &&
                o_ccii_ena && !o_read_out_ena) begin
                i_abort = 1'b1;
                aborted = 1;
            end
        end
        i_ic_ack = 1'b0;
        check({tag, "_reached_end"}, 32'(seen | aborted), 32'd1);
    endtask

    task automatic start_seq(input int runs, input int interval);
        i_total_runs   = 8'(runs);
        i_run_interval = 8'(interval);
        i_start        = 1'b1;
        s = m;
    endtask

    int cyc, rc, fr;

    initial begin
        repeat (3) step();
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_rc", 32'(o_run_counter), 32'd0);
        i_rstn = 1'b1;
        step();

        // three runs, interval 10, cap_ready always high
        start_seq(3, 10);
        run_seq("s1", 200, 0, 0, -1, cyc, rc, fr);
        step();
        check("s1_cycles", 32'(cyc), 32'd73);
        check("s1_first_req", 32'(fr), 32'd1);
        check("s1_pre", 32'(m[0] - s[0]), 32'd12);
        check("s1_prog", 32'(m[1] - s[1]), 32'd12);
        check("s1_ccii", 32'(m[2] - s[2]), 32'd39);
        check("s1_ro", 32'(m[3] - s[3]), 32'd9);
        check("s1_xfer", 32'(m[5] - s[5]), 32'd3);
        check("s1_done", 32'(m[6] - s[6]), 32'd1);
        check("s1_rc0", 32'(xfer_rc[s[5] % 64]), 32'd0);
        check("s1_rc1", 32'(xfer_rc[(s[5] + 1) % 64]), 32'd1);
        check("s1_rc2", 32'(xfer_rc[(s[5] + 2) % 64]), 32'd2);
        check("s1_rc_done", 32'(rc), 32'd2);
        check("s1_idle_outs", 32'(outs()), 32'd0);

        // zero runs: straight to DONE
        start_seq(0, 10);
        run_seq("s2", 10, 0, 0, -1, cyc, rc, fr);
        step();
        check("s2_cycles", 32'(cyc), 32'd1);
        check("s2_req", 32'(m[7] - s[7]), 32'd0);
        check("s2_strobes", 32'(m[0] - s[0] + m[1] - s[1] + m[2] - s[2]), 32'd0);
        check("s2_done", 32'(m[6] - s[6]), 32'd1);
        check("s2_idle_outs", 32'(outs()), 32'd0);

        // capture stalled for 20 cycles
        start_seq(1, 3);
        run_seq("s3", 200, 20, 0, -1, cyc, rc, fr);
        step();
        check("s3_cycles", 32'(cyc), 32'd38);
        check("s3_cap_valid", 32'(m[4] - s[4]), 32'd21);
        check("s3_ro", 32'(m[3] - s[3]), 32'd23);
        check("s3_ccii", 32'(m[2] - s[2]), 32'd26);
        check("s3_xfer", 32'(m[5] - s[5]), 32'd1);

        // abort during ANNEAL of run 1
        start_seq(3, 10);
        run_seq("s4", 200, 0, 0, 1, cyc, rc, fr);
        check("s4_rc_before", 32'(o_run_counter), 32'd1);
        step();
        i_abort = 1'b0;
        check("s4_abort_outs", 32'(outs()), 32'd0);
        check("s4_abort_rc", 32'(o_run_counter), 32'd0);
        repeat (3) step();
        check("s4_no_done", 32'(m[6] - s[6]), 32'd0);
        check("s4_xfer", 32'(m[5] - s[5]), 32'd1);

        // restart after abort with zero interval
        start_seq(1, 0);
        run_seq("s4b", 100, 0, 0, -1, cyc, rc, fr);
        step();
        check("s4b_cycles", 32'(cyc), 32'd16);
        check("s4b_ccii", 32'(m[2] - s[2]), 32'd4);
        check("s4b_done", 32'(m[6] - s[6]), 32'd1);

        // start during FETCH_IC is ignored
        start_seq(2, 10);
        run_seq("s5", 200, 0, 5, -1, cyc, rc, fr);
        step();
        check("s5_cycles", 32'(cyc), 32'd49);
        check("s5_xfer", 32'(m[5] - s[5]), 32'd2);
        check("s5_rc_done", 32'(rc), 32'd1);

        // 255 runs, counter stops at 254
        start_seq(255, 0);
        run_seq("s7", 5000, 0, 0, -1, cyc, rc, fr);
        step();
        check("s7_cycles", 32'(cyc), 32'd3826);
        check("s7_rc_done", 32'(rc), 32'd254);
        check("s7_xfer", 32'(m[5] - s[5]), 32'd255);

        // asynchronous reset mid-PROG
        start_seq(1, 2);
        i_ic_ack = 1'b1;
        for (int i = 0; i < 20 && !o_prog_ic; i++) begin
            step();
            i_start = 1'b0;
        end
        check("s6_in_prog", 32'(o_prog_ic), 32'd1);
        #1 i_rstn = 1'b0;
        #1 check("s6_async_outs", 32'(outs()), 32'd0);
        i_ic_ack = 1'b0;
        #2 i_rstn = 1'b1;
        step();
        check("s6_after_outs", 32'(outs()), 32'd0);

        check("excl_errors", 32'(m[8]), 32'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
